// File: rtl/mmu_pkg.sv
// Shared MMU types: PTE layout and the PTE-read responder state encoding.
package mmu_pkg;
  localparam int PTE_BYTES = 8;
  localparam int OFF_W     = $clog2(PTE_BYTES);

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [9:0]  flags;
  } pte_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} rsp_state_t;
endpackage

// File: rtl/pte_cache.sv
// Direct-mapped PTE cache: combinational lookup, single fill port, flush-all.
module pte_cache
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:OFF_W]  lookup_addr,
  output logic             hit,
  output logic [63:0]      rd_data,
  input  logic             fill,
  input  logic [63:OFF_W]  fill_addr,
  input  logic [63:0]      fill_data,
  input  logic             flush
);
  localparam int TAG_LO = OFF_W + IDX_W;
  localparam int TAG_W  = 64 - TAG_LO;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag  [ENTRIES];
  pte_t               data [ENTRIES];

  logic [IDX_W-1:0] lidx, fidx;
  assign lidx = lookup_addr[TAG_LO-1:OFF_W];
  assign fidx = fill_addr[TAG_LO-1:OFF_W];

  assign hit     = valid[lidx] && tag[lidx] == lookup_addr[63:TAG_LO];
  assign rd_data = data[lidx];

  // flush wins over a same-cycle fill
  always_ff @(posedge clk) begin
    if (!rst)        valid       <= '0;
    else if (flush)  valid       <= '0;
    else if (fill)   valid[fidx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill && !flush) begin
      tag[fidx]  <= fill_addr[63:TAG_LO];
      data[fidx] <= pte_t'(fill_data);
    end
  end
endmodule

// File: rtl/ptw_mem_responder.sv
// Serves walker PTE reads from a small PTE cache or the memory bus; stalls the
// walker until rdata holds the doubleword for the presented addr.
module ptw_mem_responder
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic        ren,
  output logic [63:0] rdata,
  output logic        mmu_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  rsp_state_t state, state_nx;

  logic             resp_valid;
  logic [63:OFF_W]  resp_addr;
  logic [63:0]      resp_data;
  logic [63:OFF_W]  req_addr;
  logic             drop;
  logic             match, lookup, hit, rsp, fill;
  logic [63:0]      hit_data;
  logic             unused_addr_lo;

  assign unused_addr_lo = ^addr[OFF_W-1:0];

  assign match     = resp_valid && resp_addr == addr[63:OFF_W];
  assign mmu_stall = ren && !match;
  assign rdata     = resp_data;
  assign lookup    = state == IDLE && ren && !match && !flush;
  // a response lands in WAIT, or in REQ when grant and data coincide
  assign rsp       = mem_rvalid && (state == WAIT || (state == REQ && mem_gnt));
  assign fill      = rsp && !drop && !flush;

  pte_cache #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cache (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (addr[63:OFF_W]),
    .hit         (hit),
    .rd_data     (hit_data),
    .fill        (fill),
    .fill_addr   (req_addr),
    .fill_data   (mem_rdata),
    .flush       (flush)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (lookup && !hit) state_nx = REQ;
      REQ:     if (mem_gnt) state_nx = mem_rvalid ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_data  <= '0;
      req_addr   <= '0;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nx;

      if (flush) resp_valid <= 1'b0;
      else if (fill) begin
        resp_valid <= 1'b1;
        resp_addr  <= req_addr;
        resp_data  <= mem_rdata;
      end else if (lookup && hit) begin
        resp_valid <= 1'b1;
        resp_addr  <= addr[63:OFF_W];
        resp_data  <= hit_data;
      end

      if (lookup && !hit) begin
        req_addr <= addr[63:OFF_W];
        mem_req  <= 1'b1;
        mem_addr <= {addr[63:OFF_W], {OFF_W{1'b0}}};
      end else if (state == REQ && mem_gnt) begin
        mem_req  <= 1'b0;
      end

      // an issued request can't be retracted, so a flush only marks its data stale
      if (rsp)                         drop <= 1'b0;
      else if (flush && state != IDLE) drop <= 1'b1;

      if (lookup && hit && hit_cnt != '1)    hit_cnt  <= hit_cnt + 32'd1;
      if (lookup && !hit && miss_cnt != '1)  miss_cnt <= miss_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_ptw_mem_responder.sv
// Random and directed walker traffic against a transaction-level cache model.
module tb_ptw_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] addr = '0;
  logic        ren = 1'b0;
  logic [63:0] rdata;
  logic        mmu_stall;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  ptw_mem_responder #(.ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ren(ren), .rdata(rdata),
    .mmu_stall(mmu_stall), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [60:0] lof(input logic [63:0] a);
    return a[63:3];
  endfunction

  function automatic logic [63:0] memval(input logic [60:0] line);
    if (line == 61'h1000_0201) return 64'h2000_0401_0000_00CF;
    return {line[31:0] ^ 32'h5A5A_C3C3, line[60:29]};
  endfunction

  // memory: grant after gd_cfg waiting cycles, data rl_cfg cycles after grant
  int          gd_cfg = 0, rl_cfg = 1, req_wait = 0, rv_cnt = 0, n_req = 0;
  logic [60:0] rv_line;
  logic [63:0] last_req_addr = '0;

  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk); #2;
      mem_gnt = 0; mem_rvalid = 0;
      if (!rst) req_wait = 0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = memval(rv_line); end
      end else if (mem_req && rst) begin
        if (req_wait < gd_cfg) req_wait++;
        else begin
          mem_gnt = 1; req_wait = 0; n_req++;
          last_req_addr = mem_addr; rv_line = mem_addr[63:3];
          if (rl_cfg == 0) begin mem_rvalid = 1; mem_rdata = memval(rv_line); end
          else rv_cnt = rl_cfg;
        end
      end
    end
  end

  // reference model: direct-mapped lines, the last delivered line, counts
  logic [60:0] mc_line [4];
  bit          mc_v [4];
  bit          resp_ok = 0;
  logic [60:0] resp_line = '0;
  int          m_hit = 0, m_miss = 0, m_req = 0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mc_v[i] = 0;
    resp_ok = 0;
  endtask

  task automatic model_fill(input logic [60:0] line);
    mc_v[line[1:0]] = 1; mc_line[line[1:0]] = line;
    resp_ok = 1; resp_line = line;
  endtask

  // hold addr/ren until the stall drops; n = stalled cycles
  task automatic run_walk(input logic [60:0] line, input int gd, input int rl,
                          input int flush_at, output int n);
    bit done = 0;
    gd_cfg = gd; rl_cfg = rl; n = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      addr = {line, 3'($urandom)}; ren = 1; flush = (c == flush_at);
      #1;
      if (!mmu_stall) begin done = 1; flush = 0; end
      else n++;
    end
    chk("walk_done", 64'(done), 64'd1);
  endtask

  task automatic access(input logic [60:0] line, input int gd, input int rl);
    int n, exp;
    if (resp_ok && resp_line == line) exp = 0;
    else if (mc_v[line[1:0]] && mc_line[line[1:0]] == line) begin exp = 1; m_hit++; end
    else begin exp = 2 + gd + rl; m_miss++; m_req++; end
    run_walk(line, gd, rl, -1, n);
    chk("stall_cycles", 64'(n), 64'(exp));
    chk("rdata", rdata, memval(line));
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    chk("mem_requests", 64'(n_req), 64'(m_req));
    model_fill(line);
  endtask

  task automatic idle(input int cycles, input bit do_flush);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      ren = 0; addr = {$urandom, $urandom}; flush = do_flush && c == 0;
      #1 chk("stall_ren_low", 64'(mmu_stall), 64'd0);
    end
    if (do_flush) model_clear();
  endtask

  initial begin
    int n;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    ren = 1; #1 chk("rst_stall_ren1", 64'(mmu_stall), 64'd1);
    ren = 0; #1 chk("rst_stall_ren0", 64'(mmu_stall), 64'd0);
    rst = 1;

    // cold miss, move away, warm hit
    access(lof(64'h8000_1008), 0, 3);
    chk("cold_mem_addr", last_req_addr, 64'h8000_1008);
    access(lof(64'h9000_0000), 0, 1);
    access(lof(64'h8000_1008), 1, 1);
    idle(3, 0);

    // conflict eviction on index 0
    access(lof(64'h1000), 0, 1);
    access(lof(64'h1020), 1, 2);
    access(lof(64'h1000), 0, 1);

    // grant and data in the same cycle
    access(lof(64'h2008), 0, 0);
    access(lof(64'h2F10), 1, 0);

    // flush while waiting for data: drained, then refetched
    model_clear();
    run_walk(lof(64'h3000), 0, 4, 2, n);
    chk("flush_wait_stall", 64'(n), 64'd12);
    m_miss += 2; m_req += 2;
    chk("flush_wait_miss", 64'(miss_cnt), 64'(m_miss));
    chk("flush_wait_reqs", 64'(n_req), 64'(m_req));
    chk("flush_wait_rdata", rdata, memval(lof(64'h3000)));
    model_fill(lof(64'h3000));
    access(lof(64'h2008), 0, 1);

    // flush while the request is still ungranted
    model_clear();
    run_walk(lof(64'h3408), 2, 1, 1, n);
    chk("flush_req_stall", 64'(n), 64'd10);
    m_miss += 2; m_req += 2;
    chk("flush_req_reqs", 64'(n_req), 64'(m_req));
    model_fill(lof(64'h3408));

    // reset in the middle of a REQ
    gd_cfg = 3;
    @(negedge clk); addr = 64'h5000; ren = 1; flush = 0;
    @(negedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("midrst_miss_cnt", 64'(miss_cnt), 64'd0);
    chk("midrst_stall_ren1", 64'(mmu_stall), 64'd1);
    ren = 0; #1 chk("midrst_stall_ren0", 64'(mmu_stall), 64'd0);
    model_clear(); m_hit = 0; m_miss = 0;
    access(lof(64'h3408), 0, 1);

    // random walks over 12 lines so indices conflict often
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 7)
        access(lof(64'h4_0000) + 61'($urandom_range(0, 11)),
               $urandom_range(0, 2), $urandom_range(0, 3));
      else if (r < 9) idle($urandom_range(1, 3), 0);
      else idle(2, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
